ar_synth_seq: RTL and testbench

- Recursive AR synthesis filter, the inverse of the AR predictor: x[t] = e[t] + sum_{i=0..p-1} a[i]*x[t-1-i].
- Consumes an innovation/residual stream and regenerates the time series. Sits on the ARIMA reconstruction/forecast path.
- Uses one time-multiplexed Q-format MAC driven by an FSM, with valid/ready handshakes on input and output.

---
 rtl/ar_synth_seq_if.sv | 31 +++
 rtl/ar_synth_seq.sv | 124 ++++++++++++
 tb/tb_ar_synth_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ar_synth_seq_if.sv
// Stream and coefficient-port bundle for the AR synthesis filter.
// The slave modport is the filter side; the master modport is the producer/consumer side.
interface ar_synth_seq_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned PMax = 10
);
    localparam int unsigned PW = $clog2(PMax + 1);
    localparam int unsigned AW = $clog2(PMax);

    logic [N-1:0]  e_in;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] p_order;
    logic          coef_load;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic [N-1:0]  x_out;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;

    modport slave (
        input  e_in, in_valid, p_order, coef_load, coef_addr, coef_data, out_ready,
        output in_ready, x_out, out_valid, overflow
    );

    modport master (
        output e_in, in_valid, p_order, coef_load, coef_addr, coef_data, out_ready,
        input  in_ready, x_out, out_valid, overflow
    );
endinterface

// File: rtl/ar_synth_seq.sv
// Recursive AR synthesis filter: x[t] = e[t] + sum a[i]*x[t-1-i], one shared Q-format MAC
// sequenced by an IDLE/MAC/OUT FSM with valid/ready on both streams.
module ar_synth_seq #(
    parameter int unsigned N    = 32,
    parameter int unsigned Q    = 15,
    parameter int unsigned PMax = 10
) (
    input logic               clk,
    input logic               rst,
    ar_synth_seq_if.slave     bus
);
    localparam int unsigned PW = $clog2(PMax + 1);
    localparam int unsigned AW = $clog2(PMax);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  x_q, x_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [PW-1:0] plat_q, plat_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  hist_q [PMax];
    logic [N-1:0]  coef_q [PMax];

    logic                  hist_shift;
    logic                  coef_we;
    logic [PW-1:0]         p_clamp;
    logic signed [2*N-1:0] mul_a, mul_b, prod, prod_sh;
    logic [N-1:0]          mul_res, sum;
    logic                  mul_ovf, add_ovf;

    // Shared datapath: tap idx_q of coef x hist, truncated toward -inf, then accumulated.
    always_comb begin
        p_clamp = (bus.p_order > PW'(PMax)) ? PW'(PMax) : bus.p_order;
        mul_a   = {{N{coef_q[idx_q[AW-1:0]][N-1]}}, coef_q[idx_q[AW-1:0]]};
        mul_b   = {{N{hist_q[idx_q[AW-1:0]][N-1]}}, hist_q[idx_q[AW-1:0]]};
        prod    = mul_a * mul_b;
        prod_sh = prod >>> Q;
        mul_res = prod_sh[N-1:0];
        mul_ovf = !((&prod_sh[2*N-1:N-1]) || !(|prod_sh[2*N-1:N-1]));
        sum     = acc_q + mul_res;
        add_ovf = (acc_q[N-1] == mul_res[N-1]) && (sum[N-1] != acc_q[N-1]);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        x_d        = x_q;
        idx_d      = idx_q;
        plat_d     = plat_q;
        ovf_d      = ovf_q;
        hist_shift = 1'b0;
        coef_we    = 1'b0;
        case (state_q)
            StIdle: begin
                coef_we = bus.coef_load && ({1'b0, bus.coef_addr} < (AW + 1)'(PMax));
                if (bus.in_valid) begin
                    acc_d  = bus.e_in;
                    plat_d = p_clamp;
                    idx_d  = '0;
                    if (p_clamp == '0) begin
                        x_d     = bus.e_in;
                        state_d = StOut;
                    end else begin
                        state_d = StMac;
                    end
                end
            end
            StMac: begin
                acc_d = sum;
                idx_d = idx_q + PW'(1);
                ovf_d = ovf_q | mul_ovf | add_ovf;
                if (idx_q == plat_q - PW'(1)) begin
                    x_d     = sum;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    hist_shift = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            x_q     <= '0;
            idx_q   <= '0;
            plat_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < PMax; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            idx_q   <= idx_d;
            plat_q  <= plat_d;
            ovf_q   <= ovf_d;
            if (hist_shift) begin
                hist_q[0] <= x_q;
                for (int i = 1; i < PMax; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
            end
            if (coef_we) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StOut);
    assign bus.x_out     = x_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_ar_synth_seq.sv
// Directed-vector bench for ar_synth_seq; expected outputs are hand-computed Q15 values.
module tb_ar_synth_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    ar_synth_seq_if #(.N(32), .PMax(10)) bus ();

    ar_synth_seq #(.N(32), .Q(15), .PMax(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_coef(input logic [3:0] addr, input logic [31:0] data);
        bus.coef_load = 1'b1;
        bus.coef_addr = addr;
        bus.coef_data = data;
        tick();
        bus.coef_load = 1'b0;
    endtask

    // Handshake one sample, then count cycles until out_valid; latency counts the accept cycle.
    task automatic accept(input string tag, input logic [31:0] e, input logic [3:0] p,
                          input int exp_lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.e_in     = e;
        bus.p_order  = p;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.coef_load = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    endtask

    task automatic drain(input string tag, input logic [31:0] exp_x);
        check({tag, "_x"}, bus.x_out, exp_x);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.e_in      = '0;
        bus.in_valid  = 1'b0;
        bus.p_order   = '0;
        bus.coef_load = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.out_ready = 1'b0;
        tick();
        do_reset();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x_out", bus.x_out, 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        // Impulse decay with a 0.5 tap written in the same cycle as the first sample.
        bus.coef_load = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 32'd16384;
        accept("imp0", 32'd32768, 4'd1, 2);
        drain("imp0", 32'd32768);
        accept("imp1", 32'd0, 4'd1, 2);
        drain("imp1", 32'd16384);
        accept("imp2", 32'd0, 4'd1, 2);
        drain("imp2", 32'd8192);
        accept("imp3", 32'd0, 4'd1, 2);
        drain("imp3", 32'd4096);

        // Order-0 passthrough; the next order-1 sample sees -5 in hist[0]: 0.5*-5 floors to -3.
        accept("ord0", 32'hFFFF_FFFB, 4'd0, 1);
        drain("ord0", 32'hFFFF_FFFB);
        accept("ord0_hist", 32'd0, 4'd1, 2);
        drain("ord0_hist", 32'hFFFF_FFFD);

        // Fibonacci with two 1.0 taps.
        do_reset();
        load_coef(4'd0, 32'd32768);
        load_coef(4'd1, 32'd32768);
        accept("fib0", 32'd32768, 4'd2, 3);
        drain("fib0", 32'd32768);
        accept("fib1", 32'd0, 4'd2, 3);
        drain("fib1", 32'd32768);
        accept("fib2", 32'd0, 4'd2, 3);
        drain("fib2", 32'd65536);
        accept("fib3", 32'd0, 4'd2, 3);
        drain("fib3", 32'd98304);
        accept("fib4", 32'd0, 4'd2, 3);
        drain("fib4", 32'd163840);

        // Backpressure: hold OUT for 5 cycles while a coefficient write is attempted.
        accept("bp", 32'd0, 4'd2, 3);
        bus.coef_load = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 32'd0;
        for (int k = 0; k < 5; k++) begin
            check("bp_x_hold", bus.x_out, 32'd262144);
            check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.coef_load = 1'b0;
        drain("bp", 32'd262144);
        accept("bp_next", 32'd0, 4'd2, 3);
        drain("bp_next", 32'd425984);

        // Overflow: 0x7FFFFFFF * 0x40000000 in Q15 does not fit 32 bits; flag is sticky.
        do_reset();
        check("ovf_clear", 32'(bus.overflow), 32'd0);
        load_coef(4'd0, 32'h7FFF_FFFF);
        accept("ovf0", 32'h4000_0000, 4'd1, 2);
        check("ovf0_flag", 32'(bus.overflow), 32'd0);
        drain("ovf0", 32'h4000_0000);
        accept("ovf1", 32'd0, 4'd1, 2);
        check("ovf1_flag", 32'(bus.overflow), 32'd1);
        drain("ovf1", 32'hFFFF_8000);
        accept("ovf2", 32'd0, 4'd1, 2);
        drain("ovf2", 32'h8000_0001);
        check("ovf2_sticky", 32'(bus.overflow), 32'd1);

        // Reset during the second MAC cycle of an order-4 sample.
        for (int i = 0; i < 4; i++) begin
            load_coef(4'(i), 32'd32768);
        end
        bus.e_in     = 32'd1;
        bus.p_order  = 4'd4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_x_out", bus.x_out, 32'd0);
        check("mid_overflow", 32'(bus.overflow), 32'd0);
        accept("post_rst", 32'd7, 4'd4, 5);
        drain("post_rst", 32'd7);

        // p_order above the maximum is clamped to 10 taps.
        accept("clamp", 32'd9, 4'd15, 11);
        drain("clamp", 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
